// File: rtl/i2c_arb_pkg.sv
// Shared types, default timing constants and the round-robin pick helper
// for the I2C bus arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_DRAIN,
        ST_FAULT
    } arb_state_t;

    localparam int DEFAULT_IDLE_CYCLES    = 64;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;
    localparam int MAX_MASTERS            = 8;

    // Returns the first requester found scanning last+1, last+2, ... mod n.
    // Scanning offsets high-to-low lets the nearest requester overwrite the rest.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [2:0]             last,
        input int                     n
    );
        logic [2:0] win;
        int         idx;
        win = last;
        for (int off = MAX_MASTERS; off >= 1; off--) begin
            idx = (int'(last) + off) % n;
            if (off <= n && req[idx[2:0]]) begin
                win = idx[2:0];
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Pad synchronizers plus START/STOP detection, bus-busy tracking and the
// bus-free-time counter that gates new grants.
module i2c_bus_monitor
    import i2c_arb_pkg::*;
#(
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl_pad,
    input  logic sda_pad,
    input  logic force_idle,
    output logic scl,
    output logic bus_busy,
    output logic bus_free,
    output logic stop
);

    localparam int FW = $clog2(IDLE_CYCLES + 1);

    logic [1:0]    scl_sync;
    logic [1:0]    sda_sync;
    logic          sda;
    logic          sda_prev;
    logic          start;
    logic          busy_nxt;
    logic          free_cycle;
    logic [FW-1:0] free_cnt;

    assign scl   = scl_sync[1];
    assign sda   = sda_sync[1];
    assign start = scl & sda_prev & ~sda;
    assign stop  = scl & ~sda_prev & sda;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        busy_nxt = bus_busy;
        if (force_idle) begin
            busy_nxt = 1'b0;
        end else if (start) begin
            busy_nxt = 1'b1;
        end else if (stop) begin
            busy_nxt = 1'b0;
        end
    end

    // The STOP cycle itself already counts toward the free time.
    assign free_cycle = scl & sda & ~busy_nxt;
    assign bus_free   = (free_cnt == FW'(IDLE_CYCLES));

    // Synchronizers reset low so the bus must be seen idle through both
    // stages before any free time accumulates.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rstn) begin
            scl_sync <= '0;
            sda_sync <= '0;
            sda_prev <= 1'b0;
            bus_busy <= 1'b0;
            free_cnt <= '0;
        end else begin
            scl_sync <= {scl_sync[0], scl_pad};
            sda_sync <= {sda_sync[0], sda_pad};
            sda_prev <= sda;
            bus_busy <= busy_nxt;
            if (!free_cycle) begin
                free_cnt <= '0;
            end else if (!bus_free) begin
                free_cnt <= free_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C bus among on-chip masters, with
// registered one-hot grant, open-drain routing and a stuck-SCL watchdog.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int IDLE_CYCLES    = DEFAULT_IDLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_MASTERS-1:0] req,
    output logic [N_MASTERS-1:0] gnt,
    input  logic [N_MASTERS-1:0] m_scl_o,
    input  logic [N_MASTERS-1:0] m_scl_t,
    input  logic [N_MASTERS-1:0] m_sda_o,
    input  logic [N_MASTERS-1:0] m_sda_t,
    output logic [N_MASTERS-1:0] m_scl_i,
    output logic [N_MASTERS-1:0] m_sda_i,
    output logic                 bus_scl_o,
    output logic                 bus_scl_t,
    output logic                 bus_sda_o,
    output logic                 bus_sda_t,
    input  logic                 bus_scl_i,
    input  logic                 bus_sda_i,
    output logic                 fault,
    input  logic                 clr_fault,
    output logic                 bus_busy
);

    localparam int LW = $clog2(N_MASTERS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [N_MASTERS-1:0] gnt_nxt;
    logic [LW-1:0]        last;
    logic [LW-1:0]        last_nxt;
    logic [TW-1:0]        to_cnt;
    logic [2:0]           pick;
    logic                 scl_s;
    logic                 bus_free;
    logic                 stop;
    logic                 active;
    logic                 timeout;

    i2c_bus_monitor #(
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_monitor (
        .clk       (clk),
        .rstn      (rstn),
        .scl_pad   (bus_scl_i),
        .sda_pad   (bus_sda_i),
        .force_idle(timeout),
        .scl       (scl_s),
        .bus_busy  (bus_busy),
        .bus_free  (bus_free),
        .stop      (stop)
    );

    assign active  = (state == ST_GRANTED) || (state == ST_DRAIN);
    assign timeout = active && !scl_s && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign pick    = rr_pick(MAX_MASTERS'(req), 3'(last), N_MASTERS);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (|req && bus_free) begin
                    last_nxt  = LW'(pick);
                    gnt_nxt   = N_MASTERS'(1) << pick;
                    state_nxt = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                // Timeout wins over a simultaneous request drop.
                if (timeout) begin
                    gnt_nxt   = '0;
                    state_nxt = ST_FAULT;
                end else if (!req[last]) begin
                    if (bus_busy) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (timeout) begin
                    gnt_nxt   = '0;
                    state_nxt = ST_FAULT;
                end else if (stop || !bus_busy) begin
                    gnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_FAULT: begin
                gnt_nxt = '0;
                if (scl_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            last   <= LW'(N_MASTERS - 1);
            to_cnt <= '0;
            fault  <= 1'b0;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            last   <= last_nxt;
            to_cnt <= (active && !scl_s && !timeout) ? to_cnt + 1'b1 : '0;
            if (timeout) begin
                fault <= 1'b1;
            end else if (clr_fault) begin
                fault <= 1'b0;
            end
        end
    end

    // Only the granted master's drive survives; an all-zero grant releases both pads.
    assign bus_scl_t = &(~gnt | m_scl_t | m_scl_o);
    assign bus_sda_t = &(~gnt | m_sda_t | m_sda_o);
    assign bus_scl_o = 1'b0;
    assign bus_sda_o = 1'b0;
    assign m_scl_i   = {N_MASTERS{bus_scl_i}};
    assign m_sda_i   = {N_MASTERS{bus_sda_i}};

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench: directed scenarios plus randomized transactions,
// compared every cycle against a behavioural bus/arbitration model.
module tb_i2c_bus_arbiter;

    localparam int N    = 4;
    localparam int IDLE = 64;
    localparam int TO   = 300;

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] m_scl_o, m_scl_t, m_sda_o, m_sda_t;
    logic [N-1:0] m_scl_i, m_sda_i;
    logic         bus_scl_o, bus_scl_t, bus_sda_o, bus_sda_t;
    logic         bus_scl_i, bus_sda_i;
    logic         fault, clr_fault, bus_busy;
    logic         ext_scl, ext_sda;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;
    bit rand_clr = 1'b0;

    // Behavioural model: owner index (-1 = none), run-lengths and event flags.
    int mo_owner, mo_last, mo_free, mo_low;
    bit mo_drain, mo_fmode, mo_fault, mo_busy;
    bit mo_mid_scl, mo_mid_sda, mo_seen_scl, mo_seen_sda, mo_prev_sda;

    logic [N-1:0] exp_gnt;
    logic         exp_scl_t, exp_sda_t;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .N_MASTERS     (N),
        .IDLE_CYCLES   (IDLE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .gnt      (gnt),
        .m_scl_o  (m_scl_o),
        .m_scl_t  (m_scl_t),
        .m_sda_o  (m_sda_o),
        .m_sda_t  (m_sda_t),
        .m_scl_i  (m_scl_i),
        .m_sda_i  (m_sda_i),
        .bus_scl_o(bus_scl_o),
        .bus_scl_t(bus_scl_t),
        .bus_sda_o(bus_sda_o),
        .bus_sda_t(bus_sda_t),
        .bus_scl_i(bus_scl_i),
        .bus_sda_i(bus_sda_i),
        .fault    (fault),
        .clr_fault(clr_fault),
        .bus_busy (bus_busy)
    );

    always_comb begin
        exp_gnt   = '0;
        exp_scl_t = 1'b1;
        exp_sda_t = 1'b1;
        if (mo_owner >= 0 && mo_owner < N) begin
            exp_gnt   = N'(1) << mo_owner;
            exp_scl_t = m_scl_t[mo_owner] | m_scl_o[mo_owner];
            exp_sda_t = m_sda_t[mo_owner] | m_sda_o[mo_owner];
        end
    end

    // Pads are the wired-AND of the expected routed drive and an external master.
    assign bus_scl_i = exp_scl_t & ext_scl;
    assign bus_sda_i = exp_sda_t & ext_sda;

    always @(posedge clk) begin : model
        bit s, d, st, sp, tmo, busy_n, drain_n, fm_n;
        int own_n, last_n;
        if (!rstn) begin
            mo_owner <= -1; mo_last <= N - 1; mo_free <= 0; mo_low <= 0;
            mo_drain <= 0; mo_fmode <= 0; mo_fault <= 0; mo_busy <= 0;
            mo_mid_scl <= 0; mo_mid_sda <= 0; mo_seen_scl <= 0; mo_seen_sda <= 0;
            mo_prev_sda <= 0;
        end else begin
            s  = mo_seen_scl;
            d  = mo_seen_sda;
            st = s && mo_prev_sda && !d;
            sp = s && !mo_prev_sda && d;
            tmo = (mo_owner >= 0) && !s && (mo_low == TO - 1);
            busy_n = tmo ? 1'b0 : st ? 1'b1 : sp ? 1'b0 : mo_busy;
            own_n = mo_owner; last_n = mo_last; drain_n = mo_drain; fm_n = mo_fmode;
            if (mo_fmode) begin
                if (s) fm_n = 0;
            end else if (mo_owner < 0) begin
                if (req != 0 && mo_free == IDLE) begin
                    for (int k = 1; k <= N; k++) begin
                        if (req[(mo_last + k) % N]) begin
                            own_n = (mo_last + k) % N;
                            break;
                        end
                    end
                    last_n = own_n;
                end
            end else if (tmo) begin
                own_n = -1; drain_n = 0; fm_n = 1;
            end else if (!mo_drain) begin
                if (!req[mo_owner]) begin
                    if (mo_busy) drain_n = 1;
                    else own_n = -1;
                end
            end else if (sp || !mo_busy) begin
                own_n = -1; drain_n = 0;
            end
            mo_low   <= (mo_owner >= 0 && !s && !tmo) ? mo_low + 1 : 0;
            mo_free  <= (s && d && !busy_n) ? ((mo_free < IDLE) ? mo_free + 1 : IDLE) : 0;
            mo_fault <= tmo ? 1'b1 : clr_fault ? 1'b0 : mo_fault;
            mo_busy  <= busy_n;
            mo_owner <= own_n; mo_last <= last_n; mo_drain <= drain_n; mo_fmode <= fm_n;
            mo_prev_sda <= mo_seen_sda;
            mo_seen_scl <= mo_mid_scl; mo_seen_sda <= mo_mid_sda;
            mo_mid_scl  <= bus_scl_i;  mo_mid_sda  <= bus_sda_i;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            check("gnt", gnt, exp_gnt);
            check("bus_scl_t", bus_scl_t, exp_scl_t);
            check("bus_sda_t", bus_sda_t, exp_sda_t);
            check("bus_busy", bus_busy, mo_busy);
            check("fault", fault, mo_fault);
            check("pad_o", {bus_scl_o, bus_sda_o}, 0);
            check("fanout", {m_scl_i, m_sda_i}, {{N{bus_scl_i}}, {N{bus_sda_i}}});
            check("gnt_onehot", $countones(gnt) <= 1, 1);
        end
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_clr) clr_fault = ($urandom_range(0, 15) == 0);
        end
    endtask

    // Drive one master line: released is either o=1 or t=1, picked at random.
    task automatic drive(input int i, input bit is_scl, input bit v);
        logic o, t;
        if (v) begin
            if ($urandom_range(0, 1) == 1) begin o = 1'b1; t = 1'($urandom_range(0, 1)); end
            else begin t = 1'b1; o = 1'($urandom_range(0, 1)); end
        end else begin
            o = 1'b0; t = 1'b0;
        end
        if (is_scl) begin m_scl_o[i] = o; m_scl_t[i] = t; end
        else begin m_sda_o[i] = o; m_sda_t[i] = t; end
    endtask

    task automatic release_all();
        m_scl_o = '1; m_scl_t = '1; m_sda_o = '1; m_sda_t = '1;
    endtask

    task automatic txn_start(input int i);
        drive(i, 0, 0); hold(3);
        drive(i, 1, 0); hold(3);
    endtask

    task automatic txn_bits(input int i, input int nb);
        repeat (nb) begin
            drive(i, 0, 1'($urandom_range(0, 1))); hold(1);
            drive(i, 1, 1); hold(3);
            drive(i, 1, 0); hold(2);
        end
    endtask

    task automatic txn_stop(input int i);
        drive(i, 0, 0); hold(2);
        drive(i, 1, 1); hold(3);
        drive(i, 0, 1); hold(3);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rstn = 1'b0;
        hold(3);
        rstn = 1'b1;
    endtask

    task automatic wait_grant(input string name, input int i);
        int n = 0;
        while (mo_owner != i && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, gnt, N'(1) << i);
    endtask

    initial begin
        int n, idx, mode, i;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rstn = 1'b0; req = '0; clr_fault = 1'b0;
        ext_scl = 1'b1; ext_sda = 1'b1;
        release_all();
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_gnt", gnt, 0);
        check("reset_pads", {bus_scl_t, bus_sda_t, bus_scl_o, bus_sda_o}, 4'b1100);
        check("reset_flags", {fault, bus_busy}, 0);

        // First grant latency from the first sample of the idle bus.
        rstn = 1'b1; req = 4'b0001;
        @(posedge clk);
        n = 0;
        while (gnt == 0 && n < 200) begin @(posedge clk); #1; n++; end
        check("grant_latency", n, 66);
        check("first_gnt", gnt, 4'b0001);
        @(negedge clk); m_scl_o[0] = 1'b0; m_scl_t[0] = 1'b0;
        #1 check("route_low", bus_scl_t, 0);
        @(negedge clk); m_scl_t[0] = 1'b1;
        #1 check("route_rel", bus_scl_t, 1);
        @(negedge clk); release_all();
        txn_start(0); txn_bits(0, 2); txn_stop(0);
        req = '0; hold(2);

        // Round-robin order with all masters requesting.
        reset_dut();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (gnt == 0 && n < 400) begin @(negedge clk); n++; end
            idx = -1;
            for (int k = 0; k < N; k++) if (gnt[k]) idx = k;
            check("rr_order", idx, exp_order[g]);
            if (idx >= 0) begin
                txn_start(idx); txn_bits(idx, 2); txn_stop(idx);
                req[idx] = 1'b0;
                if (g == 2) req[0] = 1'b1;
            end
            hold(2);
        end
        req = '0; hold(2);

        // Drain: master 1 drops req mid-transfer, re-raises, grant held until STOP.
        req = 4'b0010;
        wait_grant("drain_grant", 1);
        txn_start(1); txn_bits(1, 2);
        req[1] = 1'b0; hold(10);
        check("drain_held", gnt, 4'b0010);
        req[1] = 1'b1; hold(5);
        check("drain_rerise", gnt, 4'b0010);
        txn_stop(1);
        check("drain_end", gnt, 0);
        req = '0; hold(2);

        // Stuck-SCL watchdog.
        req = 4'b0001;
        wait_grant("to_grant", 0);
        txn_start(0);
        hold(TO + 10);
        check("to_fault", fault, 1);
        check("to_gnt", gnt, 0);
        check("to_scl_t", bus_scl_t, 1);
        req = '0; release_all(); hold(4);
        check("fault_sticky", fault, 1);
        clr_fault = 1'b1; @(negedge clk); clr_fault = 1'b0;
        check("fault_clr", fault, 0);
        hold(2);

        // External master holds the bus.
        ext_sda = 1'b0; hold(5);
        req = 4'b0010;
        repeat (4) begin ext_scl = 1'b0; hold(10); ext_scl = 1'b1; hold(10); end
        check("ext_busy", bus_busy, 1);
        check("ext_no_gnt", gnt, 0);
        hold(3);
        ext_sda = 1'b1;
        @(posedge clk);
        n = 0;
        while (gnt == 0 && n < 200) begin @(posedge clk); #1; n++; end
        check("ext_grant_latency", n, 66);
        check("ext_gnt", gnt, 4'b0010);
        @(negedge clk); req = '0; hold(2);

        // Reset in the middle of a transfer.
        req = 4'b0100;
        wait_grant("rst_grant", 2);
        txn_start(2); txn_bits(2, 1);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("rst_gnt", gnt, 0);
        check("rst_pads", {bus_scl_t, bus_sda_t, bus_scl_o, bus_sda_o}, 4'b1100);
        check("rst_flags", {fault, bus_busy}, 0);
        @(negedge clk); rstn = 1'b1; req = '0; release_all(); hold(2);

        // Randomized transactions.
        rand_clr = 1'b1;
        for (int r = 0; r < 14; r++) begin
            req = N'($urandom_range(1, 15));
            n = 0;
            while (mo_owner < 0 && n < 400) begin hold(1); n++; end
            check("rand_grant", |gnt, 1);
            if (mo_owner >= 0) begin
                i = mo_owner;
                mode = $urandom_range(0, 4);
                txn_start(i);
                if (mode == 4) begin
                    hold(TO + 5);
                    drive(i, 1, 1); drive(i, 0, 1); hold(4);
                end else begin
                    txn_bits(i, $urandom_range(1, 4));
                    if (mode == 1) begin
                        req[i] = 1'b0; hold($urandom_range(1, 5));
                        if ($urandom_range(0, 1) == 1) req[i] = 1'b1;
                    end
                    txn_stop(i);
                end
            end
            req = '0; release_all(); hold($urandom_range(1, 8));
        end
        rand_clr = 1'b0; clr_fault = 1'b0;
        hold(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
